// File: rtl/jtpopeye_cab_inputs.sv
// Cabinet input front-end: PS/2 key decode merged with joysticks, opposing-direction cleanup, coin stretch, pause toggle.
// Latency: joystick -> output 1 clk; PS/2 event -> output 2 clk (latch, then output register); coin/pause act on the same edge as their raw input.
// Backpressure: none; inputs are sampled every clock and all outputs are free-running registers.
//
// Ports:
//   i_clk, i_rst_n        clock and synchronous active-low reset
//   i_ps2_key[10:0]       {event toggle, pressed, extended, scan code}
//   i_joy_0 / i_joy_1     P1 / P2 joystick words, active high
//   i_clr_pause           forces pause low (wins over a toggle)
//   o_joystick1/2         {punch,up,down,left,right}, active low
//   o_start_button        {start2,start1}, active low
//   o_coin_input          stretched coin pulse, active low
//   o_pause               pause state, active high
//   o_key_evt             one-cycle pulse per accepted (mapped) PS/2 event
//
// Optional feature macro: JTPOPEYE_AUTOFIRE_EN (per-player autofire on joy_N[5]).

module jtpopeye_cab_inputs #(
    parameter int          COIN_W   = 20,
    parameter logic [19:0] COIN_LEN = 20'd400_000,
    parameter logic [20:0] AF_HALF  = 21'd800_000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [10:0] i_ps2_key,
    input  logic [15:0] i_joy_0,
    input  logic [15:0] i_joy_1,
    input  logic        i_clr_pause,
    output logic [4:0]  o_joystick1,
    output logic [4:0]  o_joystick2,
    output logic [1:0]  o_start_button,
    output logic        o_coin_input,
    output logic        o_pause,
    output logic        o_key_evt
);

    // Key latch vector indices
    localparam int K_R     = 0;
    localparam int K_L     = 1;
    localparam int K_D     = 2;
    localparam int K_U     = 3;
    localparam int K_PUNCH = 4;
    localparam int K_ST1   = 5;
    localparam int K_ST2   = 6;
    localparam int K_COIN  = 7;
    localparam int K_PAUSE = 8;

    localparam logic [COIN_W-1:0] COIN_LAST = COIN_W'(COIN_LEN) - 1'b1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } coin_state_t;

    // ------------------------------------------------------------------
    // PS/2 decode
    // ------------------------------------------------------------------
    logic        r_strobe_q;
    logic [8:0]  r_key;
    logic        r_key_evt;
    logic        w_evt;
    logic        w_pressed;
    logic        w_ext;
    logic [7:0]  w_code;
    logic [8:0]  w_key_sel;

    assign w_evt     = i_ps2_key[10] ^ r_strobe_q;
    assign w_pressed = i_ps2_key[9];
    assign w_ext     = i_ps2_key[8];
    assign w_code    = i_ps2_key[7:0];

    // One-hot select of the latch a scan code maps to; zero for unmapped codes.
    always_comb begin
        w_key_sel = '0;
        if (w_code == 8'h14) begin
            // Ctrl: left and right ctrl both fire, so ext is a don't-care
            w_key_sel[K_PUNCH] = 1'b1;
        end else if (w_ext) begin
            case (w_code)
                8'h75:   w_key_sel[K_U] = 1'b1;
                8'h72:   w_key_sel[K_D] = 1'b1;
                8'h6B:   w_key_sel[K_L] = 1'b1;
                8'h74:   w_key_sel[K_R] = 1'b1;
                default: w_key_sel      = '0;
            endcase
        end else begin
            case (w_code)
                8'h05:   w_key_sel[K_ST1]   = 1'b1;
                8'h06:   w_key_sel[K_ST2]   = 1'b1;
                8'h04:   w_key_sel[K_COIN]  = 1'b1;
                8'h0C:   w_key_sel[K_PAUSE] = 1'b1;
                default: w_key_sel          = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        // Tracking the toggle even in reset keeps a stale level from
        // looking like a fresh event once reset is released.
        r_strobe_q <= i_ps2_key[10];
        if (!i_rst_n) begin
            r_key     <= '0;
            r_key_evt <= 1'b0;
        end else begin
            r_key_evt <= w_evt & (|w_key_sel);
            if (w_evt) begin
                r_key <= (r_key & ~w_key_sel) | (w_key_sel & {9{w_pressed}});
            end
        end
    end

    // ------------------------------------------------------------------
    // Autofire (optional)
    // ------------------------------------------------------------------
    logic w_af0;
    logic w_af1;

`ifdef JTPOPEYE_AUTOFIRE_EN
    logic [20:0] r_af0_cnt;
    logic [20:0] r_af1_cnt;
    logic        r_af0_ph;
    logic        r_af1_ph;

    // Phase 0 means "punch asserted", so the first edge with the button
    // held already fires.
    assign w_af0 = i_joy_0[5] & ~r_af0_ph;
    assign w_af1 = i_joy_1[5] & ~r_af1_ph;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_joy_0[5]) begin
            r_af0_cnt <= '0;
            r_af0_ph  <= 1'b0;
        end else if (r_af0_cnt == AF_HALF - 1'b1) begin
            r_af0_cnt <= '0;
            r_af0_ph  <= ~r_af0_ph;
        end else begin
            r_af0_cnt <= r_af0_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_joy_1[5]) begin
            r_af1_cnt <= '0;
            r_af1_ph  <= 1'b0;
        end else if (r_af1_cnt == AF_HALF - 1'b1) begin
            r_af1_cnt <= '0;
            r_af1_ph  <= ~r_af1_ph;
        end else begin
            r_af1_cnt <= r_af1_cnt + 1'b1;
        end
    end

    logic w_unused;
    assign w_unused = ^{i_joy_0[15:10], i_joy_1[15:6]};
`else
    assign w_af0 = 1'b0;
    assign w_af1 = 1'b0;

    logic w_unused;
    assign w_unused = ^{i_joy_0[15:10], i_joy_0[5], i_joy_1[15:6], i_joy_1[5]};
`endif

    // ------------------------------------------------------------------
    // Merge keyboard and joysticks
    // ------------------------------------------------------------------
    logic [4:0] w_p1_raw;
    logic [4:0] w_p2_raw;
    logic [1:0] w_start_raw;
    logic       w_coin_raw;
    logic       w_pause_raw;

    assign w_p1_raw = {
        r_key[K_PUNCH] | i_joy_0[4] | w_af0,
        r_key[K_U]     | i_joy_0[3],
        r_key[K_D]     | i_joy_0[2],
        r_key[K_L]     | i_joy_0[1],
        r_key[K_R]     | i_joy_0[0]
    };
    // Keyboard only drives player 1
    assign w_p2_raw    = {i_joy_1[4] | w_af1, i_joy_1[3:0]};
    assign w_start_raw = {r_key[K_ST2] | i_joy_0[7], r_key[K_ST1] | i_joy_0[6]};
    assign w_coin_raw  = r_key[K_COIN]  | i_joy_0[8];
    assign w_pause_raw = r_key[K_PAUSE] | i_joy_0[9];

    // Opposing directions on one axis cancel each other; the other axis
    // passes through. Input/output layout {punch,up,down,left,right}.
    function automatic logic [4:0] clean_dirs(input logic [4:0] raw);
        logic [4:0] res;
        res = raw;
        if (raw[3] && raw[2]) res[3:2] = 2'b00;
        if (raw[1] && raw[0]) res[1:0] = 2'b00;
        return res;
    endfunction

    logic [4:0] r_joystick1;
    logic [4:0] r_joystick2;
    logic [1:0] r_start_button;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_joystick1    <= '1;
            r_joystick2    <= '1;
            r_start_button <= '1;
        end else begin
            r_joystick1    <= ~clean_dirs(w_p1_raw);
            r_joystick2    <= ~clean_dirs(w_p2_raw);
            r_start_button <= ~w_start_raw;
        end
    end

    // ------------------------------------------------------------------
    // Coin stretcher
    // ------------------------------------------------------------------
    coin_state_t       r_coin_state;
    coin_state_t       w_coin_state_nxt;
    logic [COIN_W-1:0] r_coin_cnt;
    logic [COIN_W-1:0] w_coin_cnt_nxt;
    logic              r_coin_out;
    logic              w_coin_out_nxt;
    logic              r_coin_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_coin_state <= S_IDLE;
            r_coin_cnt   <= '0;
            r_coin_out   <= 1'b1;
            r_coin_prev  <= 1'b0;
        end else begin
            r_coin_state <= w_coin_state_nxt;
            r_coin_cnt   <= w_coin_cnt_nxt;
            r_coin_out   <= w_coin_out_nxt;
            r_coin_prev  <= w_coin_raw;
        end
    end

    // Low time is COIN_LEN edges: entered with cnt=0, released when the
    // counter has seen COIN_LEN-1. Rising edges in HOLD are ignored so a
    // bouncing or re-pressed coin cannot extend or re-arm the pulse.
    always_comb begin
        w_coin_state_nxt = r_coin_state;
        w_coin_cnt_nxt   = r_coin_cnt;
        w_coin_out_nxt   = r_coin_out;
        case (r_coin_state)
            S_IDLE: begin
                if (w_coin_raw && !r_coin_prev) begin
                    w_coin_state_nxt = S_HOLD;
                    w_coin_cnt_nxt   = '0;
                    w_coin_out_nxt   = 1'b0;
                end
            end
            S_HOLD: begin
                if (r_coin_cnt == COIN_LAST) begin
                    w_coin_state_nxt = S_IDLE;
                    w_coin_out_nxt   = 1'b1;
                end else begin
                    w_coin_cnt_nxt = r_coin_cnt + 1'b1;
                end
            end
            default: begin
                w_coin_state_nxt = S_IDLE;
                w_coin_out_nxt   = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pause toggle
    // ------------------------------------------------------------------
    logic r_pause;
    logic r_pause_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pause      <= 1'b0;
            r_pause_prev <= 1'b0;
        end else begin
            r_pause_prev <= w_pause_raw;
            if (i_clr_pause) begin
                r_pause <= 1'b0;
            end else if (w_pause_raw && !r_pause_prev) begin
                r_pause <= ~r_pause;
            end
        end
    end

    assign o_joystick1    = r_joystick1;
    assign o_joystick2    = r_joystick2;
    assign o_start_button = r_start_button;
    assign o_coin_input   = r_coin_out;
    assign o_pause        = r_pause;
    assign o_key_evt      = r_key_evt;

endmodule
